// File: rtl/ahb_vga_writer_pkg.sv
// Shared constants and types for the AHB VGA write initiator.
// Latency: none (definitions only).
// Backpressure: not applicable.
package ahb_vga_pkg;

   // AHB-Lite encodings used by this initiator
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   // VGA slave map: console register sits at the base, image words above the offset
   localparam logic [31:0] VGA_BASE_ADDR    = 32'h5000_0000;
   localparam logic [31:0] VGA_IMAGE_OFFSET = 32'h0001_0000;

   localparam int PIX_W  = 14;
   localparam int DATA_W = 8;

   // One queued write request: destination, pixel word index, payload byte
   typedef struct packed {
      logic              target;   // 0 = console, 1 = image
      logic [PIX_W-1:0]  pix;
      logic [DATA_W-1:0] data;
   } req_entry_t;

   // Byte address of a request's target word
   function automatic logic [31:0] vga_addr(input req_entry_t e,
                                            input logic [31:0] base,
                                            input logic [31:0] image_ofs);
      logic [31:0] pix_byte;
      pix_byte = {{(32 - PIX_W - 2){1'b0}}, e.pix, 2'b00};
      return e.target ? (base + image_ofs + pix_byte) : base;
   endfunction

endpackage

// File: rtl/ahb_vga_writer_if.sv
// Request stream plus AHB-Lite initiator signals for the VGA writer.
// Latency: none (wires only).
// Backpressure: req_ready on the request side, HREADY on the AHB side.
// Ports: master = the writer (drives AHB outputs, req_ready, status);
//        slave  = the environment (request source and AHB slave).
interface ahb_vga_writer_if;

   // request stream
   logic        req_valid;
   logic        req_ready;
   logic        req_target;
   logic [13:0] req_pix;
   logic [7:0]  req_data;

   // AHB-Lite
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HRESP;

   // status
   logic        busy;
   logic [7:0]  err_count;

   modport master (
      input  req_valid, req_target, req_pix, req_data, HREADY, HRESP,
      output req_ready, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
             HMASTLOCK, HWDATA, busy, err_count
   );

   modport slave (
      output req_valid, req_target, req_pix, req_data, HREADY, HRESP,
      input  req_ready, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT,
             HMASTLOCK, HWDATA, busy, err_count
   );

endinterface

// File: rtl/ahb_vga_writer_sync_fifo.sv
// Synchronous FIFO with show-ahead head output and full/empty flags.
// Latency: a pushed word is visible on head_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk/rst (sync, active high), push/push_dat, pop, head_dat, full, empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty when indices match
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: flushed pointers make stale contents unreachable
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/ahb_vga_writer.sv
// AHB-Lite initiator turning queued byte requests into single NONSEQ word writes to the VGA slave.
// Latency: push at edge k -> NONSEQ in cycle k+1 -> HWDATA in cycle k+2; 1 write/cycle sustained.
// Backpressure: req_ready low while FIFO full; HREADY low freezes address and data phases.
// Ports: HCLK, HRESET (sync, active high), bus (master modport: request stream, AHB, busy, err_count).
module ahb_vga_writer
   import ahb_vga_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = VGA_BASE_ADDR,
   parameter logic [31:0] IMAGE_OFFSET = VGA_IMAGE_OFFSET,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic               HCLK,
   input  logic               HRESET,
   ahb_vga_writer_if.master   bus
);

   req_entry_t  push_dat;
   req_entry_t  head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        issue;
   logic        accept;
   logic        dp_valid;
   logic [31:0] dp_data;
   logic        cancel;
   logic [7:0]  err_cnt;

   assign push_dat = '{target: bus.req_target, pix: bus.req_pix, data: bus.req_data};

   // req_ready depends on full only, so a full FIFO never sees push+pop together
   assign bus.req_ready = ~fifo_full & ~HRESET;
   assign push          = bus.req_valid & bus.req_ready;

   sync_fifo #(
      .WIDTH ($bits(req_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (HCLK),
      .rst      (HRESET),
      .push     (push),
      .push_dat (push_dat),
      .pop      (accept),
      .head_dat (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Address phase straight off the FIFO head; cancel forces the IDLE slot
   // required between the two cycles of an ERROR response.
   assign issue  = ~fifo_empty & ~cancel & ~HRESET;
   assign accept = issue & bus.HREADY;

   assign bus.HTRANS    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.HWRITE    = issue;
   assign bus.HADDR     = issue ? vga_addr(head, BASE_ADDR, IMAGE_OFFSET) : 32'h0;
   assign bus.HSIZE     = HSIZE_WORD;
   assign bus.HBURST    = HBURST_SINGLE;
   assign bus.HPROT     = HPROT_DEFAULT;
   assign bus.HMASTLOCK = 1'b0;
   assign bus.HWDATA    = dp_data;

   assign bus.busy      = ~fifo_empty | dp_valid;
   assign bus.err_count = err_cnt;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_valid <= 1'b0;
         dp_data  <= 32'h0;
         cancel   <= 1'b0;
         err_cnt  <= 8'h0;
      end else if (bus.HREADY) begin
         // Data phase ends (OKAY or second ERROR cycle); back-to-back reload if accepted
         dp_valid <= accept;
         if (accept) dp_data <= {24'h0, head.data};
         cancel   <= 1'b0;
      end else if (dp_valid && bus.HRESP && !cancel) begin
         // First ERROR cycle: suppress the pending address phase, count once.
         // The head stays queued and is reissued after the error completes.
         cancel <= 1'b1;
         if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ahb_vga_writer.sv
module tb_ahb_vga_writer;
   import ahb_vga_pkg::*;

   logic HCLK = 1'b0;
   logic HRESET;
   always #5 HCLK = ~HCLK;

   ahb_vga_writer_if bus ();

   ahb_vga_writer dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_bad  = 0;
   int   n_done = 0;
   int   err_exp = 0;

   // Reference address map: console at base, image words 4 bytes apart above the offset
   function automatic logic [31:0] model_addr(input bit target, input int pix);
      if (target) return 32'h5000_0000 + 32'h0001_0000 + 32'(pix) * 4;
      return 32'h5000_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit          mon_pend = 0;
   logic [31:0] mon_addr;

   always @(negedge HCLK) begin
      exp_t e;
      if (HRESET) begin
         mon_pend = 0;
      end else begin
         if (mon_pend && bus.HREADY) begin
            mon_pend = 0;
            n_done++;
            if (sb_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL sb_unexpected: write addr %h data %h with nothing expected", mon_addr, bus.HWDATA);
            end else begin
               e = sb_q.pop_front();
               if (bus.HRESP) begin
                  chk("err_write_addr", mon_addr, e.addr);
                  chk("err_write_data", bus.HWDATA, e.data);
               end else begin
                  chk("write_addr", mon_addr, e.addr);
                  chk("write_data", bus.HWDATA, e.data);
               end
            end
         end
         if (bus.HTRANS == HTRANS_NONSEQ && bus.HREADY) begin
            mon_pend = 1;
            mon_addr = bus.HADDR;
            chk("ctrl", {19'h0, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK},
                {19'h0, 1'b1, 3'b010, 3'b000, 4'b0011, 1'b0});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input bit t, input logic [13:0] pix, input logic [7:0] d);
      int waited = 0;
      bus.req_valid  = 1'b1;
      bus.req_target = t;
      bus.req_pix    = pix;
      bus.req_data   = d;
      @(negedge HCLK);
      while (!bus.req_ready && waited < 2000) begin
         @(negedge HCLK);
         waited++;
      end
      if (!bus.req_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL push_timeout: req_ready stuck at 0 for data %h", d);
      end else begin
         sb_q.push_back('{model_addr(t, int'(pix)), {24'h0, d}});
      end
      @(posedge HCLK);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      while ((sb_q.size() != 0 || bus.busy) && n < 100) begin
         tick();
         n++;
      end
      chk({name, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
      chk({name, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   // Single console write 'H' with HREADY high: full cycle-by-cycle timing check
   task automatic scenario_h(input string tag);
      push(1'b0, 14'd0, 8'h48);
      chk({tag, "_k1_haddr"},  bus.HADDR, 32'h5000_0000);
      chk({tag, "_k1_htrans"}, 32'(bus.HTRANS), 32'(2'b10));
      chk({tag, "_k1_hwrite"}, 32'(bus.HWRITE), 32'd1);
      tick();
      chk({tag, "_k2_hwdata"}, bus.HWDATA, 32'h0000_0048);
      chk({tag, "_k2_htrans"}, 32'(bus.HTRANS), 32'(2'b00));
      chk({tag, "_k2_busy"},   32'(bus.busy), 32'd1);
      tick();
      chk({tag, "_k3_busy"},   32'(bus.busy), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int bad_cycles;
      int done0;
      logic [7:0] b;

      HRESET         = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_target = 1'b0;
      bus.req_pix    = '0;
      bus.req_data   = '0;
      bus.HREADY     = 1'b1;
      bus.HRESP      = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_htrans",    32'(bus.HTRANS), 32'd0);
      chk("rst_haddr",     bus.HADDR, 32'h0);
      chk("rst_hwdata",    bus.HWDATA, 32'h0);
      chk("rst_busy",      32'(bus.busy), 32'd0);
      chk("rst_err_count", 32'(bus.err_count), 32'd0);
      HRESET = 1'b0;
      #1;
      chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      tick();

      // console 'H'
      scenario_h("s1");

      // image pixel 5
      push(1'b1, 14'd5, 8'hE0);
      chk("img_haddr", bus.HADDR, 32'h5001_0014);
      tick();
      chk("img_hwdata", bus.HWDATA, 32'h0000_00E0);
      tick();

      // fill FIFO under wait states, then release for back-to-back writes
      bus.HREADY = 1'b0;
      for (int i = 0; i < 4; i++) push(1'b0, 14'd0, 8'h61 + 8'(i));
      chk("full_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid = 1'b1;
      bus.req_data  = 8'h99;
      @(negedge HCLK);
      chk("fifth_push_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      bus.req_valid = 1'b0;
      bus.HREADY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("b2b_htrans", 32'(bus.HTRANS), 32'(2'b10));
         if (i > 0) chk("b2b_hwdata_lag", bus.HWDATA, {24'h0, 8'h61 + 8'(i - 1)});
         tick();
      end
      chk("b2b_after_htrans", 32'(bus.HTRANS), 32'd0);
      chk("b2b_after_hwdata", bus.HWDATA, 32'h0000_0064);
      drain("b2b");

      // long scroll stall with next request queued
      done0 = n_done;
      push(1'b0, 14'd0, 8'h41);
      push(1'b0, 14'd0, 8'h42);
      bus.HREADY = 1'b0;
      bad_cycles = 0;
      for (int i = 0; i < 1000; i++) begin
         if (bus.HWDATA !== 32'h41 || bus.HADDR !== 32'h5000_0000 || bus.HTRANS !== 2'b10)
            bad_cycles++;
         tick();
      end
      chk("stall_frozen_cycles", 32'(bad_cycles), 32'd0);
      drain("stall");
      chk("stall_completions", 32'(n_done - done0), 32'd2);

      // two-cycle ERROR on 0x10 while 0x11 waits in the address phase
      done0 = n_done;
      push(1'b0, 14'd0, 8'h10);
      push(1'b0, 14'd0, 8'h11);
      bus.HREADY = 1'b0;
      bus.HRESP  = 1'b1;
      err_exp++;
      chk("err1_htrans", 32'(bus.HTRANS), 32'(2'b10));
      tick();
      chk("err2_htrans_idle", 32'(bus.HTRANS), 32'd0);
      chk("err_count", 32'(bus.err_count), 32'(err_exp));
      bus.HREADY = 1'b1;
      tick();
      bus.HRESP = 1'b0;
      chk("err_reissue_htrans", 32'(bus.HTRANS), 32'(2'b10));
      chk("err_reissue_hwrite", 32'(bus.HWRITE), 32'd1);
      drain("err");
      chk("err_completions", 32'(n_done - done0), 32'd2);
      chk("err_count_hold", 32'(bus.err_count), 32'(err_exp));

      // reset with entries queued under wait states
      bus.HREADY = 1'b0;
      for (int i = 0; i < 3; i++) push(1'b1, 14'(i + 7), 8'h20 + 8'(i));
      HRESET = 1'b1;
      #1;
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      HRESET = 1'b0;
      sb_q.delete();
      err_exp = 0;
      chk("midrst_htrans",    32'(bus.HTRANS), 32'd0);
      chk("midrst_busy",      32'(bus.busy), 32'd0);
      chk("midrst_err_count", 32'(bus.err_count), 32'd0);
      chk("midrst_hwdata",    bus.HWDATA, 32'h0);
      bus.HREADY = 1'b1;
      tick();
      scenario_h("s6");

      // randomized traffic with random wait states
      for (int c = 0; c < 400; c++) begin
         bus.HREADY     = ($urandom_range(0, 3) != 0);
         bus.req_valid  = 1'($urandom_range(0, 1));
         bus.req_target = 1'($urandom_range(0, 1));
         bus.req_pix    = 14'($urandom_range(0, 16383));
         b              = 8'($urandom_range(0, 255));
         bus.req_data   = b;
         @(negedge HCLK);
         if (bus.req_valid && bus.req_ready)
            sb_q.push_back('{model_addr(bus.req_target, int'(bus.req_pix)), {24'h0, b}});
         tick();
      end
      bus.req_valid = 1'b0;
      drain("rand");
      chk("rand_err_count", 32'(bus.err_count), 32'(err_exp));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
